// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 3-to-8 grant decoder.
// Holds the FSM state encoding, the illegal-code constant and the one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  // {GS,EO} both high is a contradictory encoder output
  localparam logic [1:0] ILLEGAL_CODE = 2'b11;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/decoder_38_grant_if.sv
// Encoder-side inputs and grant-side outputs of the grant decoder.
// The driver of the encoded request uses master, the decoder uses slave.
interface decoder_38_grant_if;
  logic       E;
  logic [2:0] Y;
  logic       GS;
  logic       EO;
  logic       ready;
  logic [7:0] G;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output E, Y, GS, EO,
    input  ready, G, busy, done, err
  );

  modport slave (
    input  E, Y, GS, EO,
    output ready, G, busy, done, err
  );
endinterface

// File: rtl/decoder_38.sv
// Combinational 3-to-8 decoder with enable.
// Output is all-zero when disabled.
module decoder_38
  import decoder_pkg::*;
(
  input  logic       i_en,
  input  logic [2:0] i_idx,
  output logic [7:0] o_g
);

  assign o_g = i_en ? onehot8(i_idx) : 8'h00;

endmodule

// File: rtl/decoder_38_grant.sv
// Registered grant decoder: turns an encoder index into a timed one-hot
// grant with a fixed hold time followed by an optional idle gap.
module decoder_38_grant
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  decoder_38_grant_if.slave  bus
);

  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_g;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_illegal;
  logic          w_hold;
  logic          w_en;
  logic [2:0]    w_idx;
  logic [7:0]    w_g;

  assign w_accept  = (r_state == IDLE) && bus.E && bus.GS && !bus.EO;
  assign w_illegal = (r_state == IDLE) && bus.E &&
                     ({bus.GS, bus.EO} == ILLEGAL_CODE);
  // Grant continues into the next cycle only while enabled and not expiring
  assign w_hold    = (r_state == GRANT) && bus.E && (r_cnt != '0);
  assign w_en      = w_accept || w_hold;
  assign w_idx     = w_accept ? bus.Y : r_idx;

  decoder_38 u_dec (
    .i_en  (w_en),
    .i_idx (w_idx),
    .o_g   (w_g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_g     <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_g    <= w_g;
      r_done <= 1'b0;
      r_err  <= w_illegal;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= GRANT;
            r_idx   <= bus.Y;
            r_cnt   <= HOLD_LD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= (HOLD_LD == '0);
          end
        end
        GRANT: begin
          if (!bus.E) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              r_state <= GAP;
              r_cnt   <= GAP_LD;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt  <= r_cnt - CW'(1);
            r_done <= (r_cnt == CW'(1));
          end
        end
        GAP: begin
          if (!bus.E || (r_cnt == '0)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.G     = r_g;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_decoder_38_grant.sv
// Bench for decoder_38_grant: a HOLD=4/GAP=1 and a HOLD=4/GAP=0 instance
// driven in parallel and compared every cycle against an elapsed-time model.
module tb_decoder_38_grant;

  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic       e;
  logic [2:0] y;
  logic       gs;
  logic       eo;

  int n_chk = 0;
  int n_fail = 0;

  decoder_38_grant_if if0 ();
  decoder_38_grant_if if1 ();

  assign if0.E = e;
  assign if0.Y = y;
  assign if0.GS = gs;
  assign if0.EO = eo;
  assign if1.E = e;
  assign if1.Y = y;
  assign if1.GS = gs;
  assign if1.EO = eo;

  decoder_38_grant #(.HOLD_CYCLES(H), .GAP_CYCLES(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  decoder_38_grant #(.HOLD_CYCLES(H), .GAP_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: age = cycles since accept (0 = idle)
  int         age [2];
  logic [2:0] midx [2];
  logic       merr [2];
  int         gp [2];

  function automatic logic [11:0] exp_vec(int d);
    logic [7:0] g;
    g = (age[d] >= 1 && age[d] <= H) ? (8'd1 << midx[d]) : 8'd0;
    return {age[d] == 0, age[d] != 0, age[d] == H, merr[d], g};
  endfunction

  function automatic logic [11:0] act_vec(int d);
    if (d == 0)
      return {if0.ready, if0.busy, if0.done, if0.err, if0.G};
    return {if1.ready, if1.busy, if1.done, if1.err, if1.G};
  endfunction

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic mchk();
    chk("model_gap1", act_vec(0), exp_vec(0));
    chk("model_gap0", act_vec(1), exp_vec(1));
  endtask

  task automatic mstep(int d);
    merr[d] = 1'b0;
    if (age[d] == 0) begin
      if (e && gs && !eo) begin
        age[d] = 1;
        midx[d] = y;
      end else if (e && gs && eo) begin
        merr[d] = 1'b1;
      end
    end else if (!e) begin
      age[d] = 0;
    end else begin
      age[d]++;
      if (age[d] > H + gp[d]) age[d] = 0;
    end
  endtask

  task automatic cyc(logic ie, logic [2:0] iy, logic igs, logic ieo);
    e = ie;
    y = iy;
    gs = igs;
    eo = ieo;
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    mchk();
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      age[d] = 0;
      merr[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mreset();
    #1;
    chk("rst_now_g0", {4'b0, if0.G}, 12'h000);
    chk("rst_now_g1", {4'b0, if1.G}, 12'h000);
    mchk();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       e;
    logic [2:0] y;
    logic       gs;
    logic       eo;
    logic [7:0] g;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t tbl [7];
  logic [7:0] b2b [9];

  initial begin
    tbl[0] = '{1'b1, 3'd5, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3'd0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 3'd2, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    b2b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
            8'h01, 8'h01, 8'h01, 8'h01};
    gp[0] = 1;
    gp[1] = 0;
    midx[0] = 3'd0;
    midx[1] = 3'd0;
    mreset();

    rst = 1'b1;
    e = 1'b0;
    y = 3'd0;
    gs = 1'b0;
    eo = 1'b0;
    #3;
    chk("reset_vals", act_vec(0), 12'h800);
    chk("reset_vals1", act_vec(1), 12'h800);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle responses from IDLE
    for (int i = 0; i < 7; i++) begin
      do_reset();
      cyc(tbl[i].e, tbl[i].y, tbl[i].gs, tbl[i].eo);
      chk($sformatf("tbl%0d_g", i), {4'b0, if0.G}, {4'b0, tbl[i].g});
      chk($sformatf("tbl%0d_rdy", i), {11'b0, if0.ready},
          {11'b0, tbl[i].rdy});
      chk($sformatf("tbl%0d_err", i), {11'b0, if0.err},
          {11'b0, tbl[i].err});
    end

    // Single grant with gap
    do_reset();
    cyc(1'b1, 3'd5, 1'b1, 1'b0);
    for (int i = 1; i <= H; i++) begin
      chk("single_g", {4'b0, if0.G}, 12'h020);
      chk("single_done", {11'b0, if0.done}, {11'b0, i == H});
      cyc(1'b1, 3'd0, 1'b0, 1'b1);
    end
    chk("gap_g", {4'b0, if0.G}, 12'h000);
    chk("gap_busy_rdy", {10'b0, if0.busy, if0.ready}, 12'h002);
    cyc(1'b1, 3'd0, 1'b0, 1'b1);
    chk("after_gap_rdy", {11'b0, if0.ready}, 12'h001);

    // Back-to-back on the no-gap instance
    do_reset();
    cyc(1'b1, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_%0d", i), {4'b0, if1.G}, {4'b0, b2b[i]});
      cyc(1'b1, 3'd0, 1'b1, 1'b0);
    end

    // Abort in the second grant cycle
    do_reset();
    cyc(1'b1, 3'd6, 1'b1, 1'b0);
    cyc(1'b1, 3'd6, 1'b0, 1'b1);
    chk("abort_g2", {4'b0, if0.G}, 12'h040);
    cyc(1'b0, 3'd6, 1'b0, 1'b1);
    chk("abort_g", {4'b0, if0.G}, 12'h000);
    chk("abort_rdy", {11'b0, if0.ready}, 12'h001);
    for (int i = 0; i < 4; i++) begin
      chk("abort_nodone", {10'b0, if0.done, if1.done}, 12'h000);
      cyc(1'b1, 3'd0, 1'b0, 1'b1);
    end

    // Reset in the middle of a grant, then a full-length grant
    do_reset();
    cyc(1'b1, 3'd2, 1'b1, 1'b0);
    cyc(1'b1, 3'd0, 1'b0, 1'b1);
    chk("midgrant_g", {4'b0, if0.G}, 12'h004);
    do_reset();
    cyc(1'b1, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < H; i++) begin
      chk("post_rst_g", {4'b0, if0.G}, 12'h002);
      cyc(1'b1, 3'd0, 1'b0, 1'b1);
    end
    chk("post_rst_end", {4'b0, if0.G}, 12'h000);

    // Random traffic, biased toward requests with occasional aborts
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 10) != 0, 3'($urandom),
          ($urandom % 4) != 0, ($urandom % 4) == 0);
      if (($urandom % 150) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_38_grant.md
# decoder_38_grant

Registered 3-to-8 decoder that consumes the encoded output of the 8-3 priority encoder (Y, GS, EO) and turns it back into a one-hot grant line. It holds each grant for a fixed number of cycles, then inserts an idle gap. It completes the request/grant loop: the encoder compresses eight requests into an index, and this block expands the index into a timed, exclusive grant. It sits after the encoder in the arbitration path of the beginner-series designs.

## Interface
Parameters:
- HOLD_CYCLES, 4, cycles each grant stays asserted; legal range ≥ 1.
- GAP_CYCLES, 1, idle cycles after each grant before the next accept; 0 allowed (no gap).

Ports:
- clk  input  1  single clock for the block; all logic on rising edge.
- rst  input  1  reset is asynchronous and active-high.
- E  input  1  block enable, active-high; mirrors the encoder EI.
- Y  input  3  encoded request index from the encoder.
- GS  input  1  group select: high means Y is a valid request.
- EO  input  1  enable-out: high means no request is pending.
- ready  output  1  high in IDLE; a request is accepted only when ready is high.
- G  output  8  one-hot grant, active-high, registered.
- busy  output  1  high in GRANT and GAP.
- done  output  1  one-cycle pulse coincident with the last grant cycle.
- err  output  1  one-cycle pulse on an illegal encoder code.

## Operation
- Three states: IDLE, GRANT, GAP.
- Encoding and constants live in the shared package.

IDLE:
- ready=1, G=0, busy=0.
- A request is accepted on a rising edge when E=1, GS=1 and EO=0. On accept, latch Y into idx, load the counter with HOLD_CYCLES-1, and go to GRANT.
- E=1 with GS=1 and EO=1 is illegal. Pulse err for one cycle, accept nothing, stay in IDLE.
- GS=0 with EO=1 means no request: stay in IDLE.
- GS=0 with EO=0 arises only when E=0 or while the encoder is disabled: stay in IDLE. err stays low.

GRANT:
- G = 8'b1 << idx, i.e. bit idx only. busy=1, ready=0.
- The counter decrements each cycle.
- When the counter is 0, done=1 for that cycle. The next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- Y, GS and EO are ignored while in GRANT.

GAP:
- G=0, busy=1, ready=0.
- Counts GAP_CYCLES cycles, then goes to IDLE.

Abort and reset:
- E=0 sampled in GRANT or GAP: the next state is IDLE and G=0 on the following cycle.
- No done pulse is produced for an aborted grant.
- Asserting rst at any time forces IDLE and clears all outputs immediately. This includes reset in the middle of a grant.

Counter and output rules:
- One shared down-counter, width $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- No wrap-around: the counter is reloaded on every state entry.
- G is never multi-hot and never non-zero outside GRANT.

## Timing
Reset values: ready=1, G=8'h00, busy=0, done=0, err=0, state=IDLE, idx=0.

Accept and grant timing:
- Inputs are sampled at edge k.
- G is valid from cycle k+1 through cycle k+HOLD_CYCLES, inclusive.
- done is high in cycle k+HOLD_CYCLES.

Gap and next accept:
- The GAP state occupies cycles k+HOLD_CYCLES+1 through k+HOLD_CYCLES+GAP_CYCLES.
- ready is high again in cycle k+HOLD_CYCLES+GAP_CYCLES+1.
- The earliest next accept is at the end of that cycle.
- With GAP_CYCLES=0, ready returns in cycle k+HOLD_CYCLES+1, so grants run back-to-back with a single cycle at G=0.

Other timing:
- err is registered: it pulses in cycle k+1 for an illegal code sampled at edge k.
- Abort latency is one cycle from sampling E=0 to G=0.

## Structure
Package decoder_pkg holds:
- the state enum (IDLE, GRANT, GAP);
- a function onehot8(idx) returning 8'b1 << idx;
- a localparam for the illegal-code check.

Sub-module decoder_38:
- Purely combinational 3-to-8 decoder with enable: G_int = en ? onehot8(idx) : 0.
- The top level registers its output into G.

The FSM, counter and idx latch stay in decoder_38_grant.

## Test plan
- Reset: assert rst mid-cycle -> immediately G=8'h00, ready=1, busy=0, done=0, err=0.
- Single grant (HOLD=4, GAP=1): E=1, Y=3'b101, GS=1, EO=0 for one cycle -> G=8'b0010_0000 for exactly 4 cycles, done high in the 4th, G=0 and busy=1 for 1 cycle, then ready=1.
- Back-to-back (GAP=0): hold Y=3'b111 then Y=3'b000 valid continuously -> G=8'h80 for 4 cycles, one cycle at 0, then G=8'h01 for 4 cycles. Inputs during GRANT are ignored.
- Illegal code: E=1, GS=1, EO=1 -> err pulses one cycle, G stays 8'h00, ready stays 1.
- Abort: drop E to 0 in the 2nd grant cycle -> G=0 on the next cycle, state IDLE, done never pulses.
- Reset mid-grant: rst during GRANT with Y=3'b010 -> G=0 immediately. After release, a new request with Y=3'b001 gives a G=8'h02 grant of the full HOLD length.
